// File: rtl/instr_loader.sv
// Program loader: assembles opcode-first 32-bit words from a byte stream and writes them to instruction memory.
// Registered Moore FSM, 5 cycles/word minimum; BYTE_READY only in RECV, CPU held until a clean complete load.
module instr_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] MAX_OPCODE = 8'h0D
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [7:0]            BYTE_IN,
  input  logic                  BYTE_VALID,
  output logic                  BYTE_READY,
  input  logic                  LAST,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  output logic [31:0]           IMEM_WDATA,
  output logic                  IMEM_WE,
  output logic                  CPU_HOLD,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [ADDR_WIDTH:0]   WORD_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                r_state;
  logic [1:0]            r_idx;
  logic [23:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_last;
  logic                  r_ready;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_error;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [31:0]           r_imem_wdata;

  logic w_xfer;
  logic w_bad_opcode;

  assign w_xfer       = BYTE_VALID && r_ready;
  assign w_bad_opcode = (r_idx == 2'd0) && (BYTE_IN > MAX_OPCODE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_word       <= '0;
      r_addr       <= '0;
      r_count      <= '0;
      r_last       <= 1'b0;
      r_ready      <= 1'b0;
      r_hold       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (START) begin
            r_state <= S_RECV;
            r_addr  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_hold  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        S_RECV: begin
          if (w_xfer) begin
            // An illegal opcode or an early LAST both consume the byte and abort.
            if (w_bad_opcode || (LAST && (r_idx != 2'd3))) begin
              r_state <= S_ERR;
              r_ready <= 1'b0;
              r_error <= 1'b1;
            end else if (r_idx == 2'd3) begin
              r_state      <= S_WRITE;
              r_ready      <= 1'b0;
              r_last       <= LAST;
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_addr;
              r_imem_wdata <= {r_word, BYTE_IN};
            end else begin
              case (r_idx)
                2'd0:    r_word[23:16] <= BYTE_IN;
                2'd1:    r_word[15:8]  <= BYTE_IN;
                default: r_word[7:0]   <= BYTE_IN;
              endcase
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + 1'b1;
          r_count <= r_count + 1'b1;
          r_idx   <= '0;
          if (r_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_hold  <= 1'b0;
          end else if (&r_addr) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else begin
            r_state <= S_RECV;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_hold  <= 1'b0;
        end
      endcase
    end
  end

  assign BYTE_READY = r_ready;
  assign CPU_HOLD   = r_hold;
  assign DONE       = r_done;
  assign ERROR      = r_error;
  assign WORD_COUNT = r_count;
  assign IMEM_WE    = r_imem_we;
  assign IMEM_ADDR  = r_imem_addr;
  assign IMEM_WDATA = r_imem_wdata;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: default-size instance for the load scenarios, 4-word instance for capacity.
module tb_instr_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        START2 = 1'b0;
  logic [7:0]  BYTE_IN = 8'h00;
  logic        BYTE_VALID = 1'b0;
  logic        LAST = 1'b0;

  logic        rdy, we, hold, done, err;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [8:0]  wcnt;

  logic        rdy2, we2, hold2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  wcnt2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [1:0]  log_addr2[$];
  logic [31:0] log_data2[$];

  always #5 CLK = ~CLK;

  instr_loader u_dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(rdy), .LAST(LAST), .IMEM_ADDR(addr), .IMEM_WDATA(wdata), .IMEM_WE(we),
    .CPU_HOLD(hold), .DONE(done), .ERROR(err), .WORD_COUNT(wcnt)
  );

  instr_loader #(.ADDR_WIDTH(2)) u_small (
    .CLK(CLK), .RESET(RESET), .START(START2), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(rdy2), .LAST(LAST), .IMEM_ADDR(addr2), .IMEM_WDATA(wdata2), .IMEM_WE(we2),
    .CPU_HOLD(hold2), .DONE(done2), .ERROR(err2), .WORD_COUNT(wcnt2)
  );

  // A write is taken by memory on the edge that ends the strobe cycle.
  always @(posedge CLK) begin
    if (we) begin
      log_addr.push_back(addr);
      log_data.push_back(wdata);
    end
    if (we2) begin
      log_addr2.push_back(addr2);
      log_data2.push_back(wdata2);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) START2 = 1'b1; else START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    START2 = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l, input bit sel, input bit bursty);
    int n;
    if (bursty && ($urandom_range(0, 1) == 1)) begin
      BYTE_VALID = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge CLK);
    end
    BYTE_IN = b;
    LAST = l;
    BYTE_VALID = 1'b1;
    n = 0;
    while (!(sel ? rdy2 : rdy) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 64'd0, 64'd1);
    else @(negedge CLK);
  endtask

  task automatic idle_src();
    BYTE_VALID = 1'b0;
    LAST = 1'b0;
  endtask

  task automatic wait_end(input bit sel);
    int n;
    n = 0;
    while (!(sel ? (done2 | err2) : (done | err)) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("end_reached", sel ? (done2 | err2) : (done | err), 64'd1);
  endtask

  task automatic two_word_load(input bit bursty);
    logic [7:0] s [8];
    s = '{8'h00, 8'h04, 8'h00, 8'h05, 8'h02, 8'h06, 8'h04, 8'h05};
    log_addr.delete();
    log_data.delete();
    pulse_start(1'b0);
    chk("recv_hold", hold, 64'd1);
    chk("recv_ready", rdy, 64'd1);
    for (int i = 0; i < 8; i++) send(s[i], (i == 7), 1'b0, bursty);
    idle_src();
    wait_end(1'b0);
    chk("tw_writes", log_addr.size(), 64'd2);
    if (log_addr.size() == 2) begin
      chk("tw_addr0", log_addr[0], 64'd0);
      chk("tw_data0", log_data[0], 64'h00040005);
      chk("tw_addr1", log_addr[1], 64'd1);
      chk("tw_data1", log_data[1], 64'h02060405);
    end
    chk("tw_done", done, 64'd1);
    chk("tw_error", err, 64'd0);
    chk("tw_count", wcnt, 64'd2);
    chk("tw_hold_released", hold, 64'd0);
    chk("tw_ready_low", rdy, 64'd0);
    chk("tw_addr_held", addr, 64'd1);
    chk("tw_wdata_held", wdata, 64'h02060405);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_rdy"}, rdy, 64'd0);
    chk({tag, "_we"}, we, 64'd0);
    chk({tag, "_hold"}, hold, 64'd0);
    chk({tag, "_done"}, done, 64'd0);
    chk({tag, "_err"}, err, 64'd0);
    chk({tag, "_addr"}, addr, 64'd0);
    chk({tag, "_wdata"}, wdata, 64'd0);
    chk({tag, "_wcnt"}, wcnt, 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    all_zero("rst");
    RESET = 1'b1;
    @(negedge CLK);
    chk("idle_ready", rdy, 64'd0);

    // Two-word load, source always valid
    two_word_load(1'b0);

    // Illegal opcode, then recovery with the highest legal opcode
    log_addr.delete();
    log_data.delete();
    pulse_start(1'b0);
    send(8'h0E, 1'b0, 1'b0, 1'b0);
    idle_src();
    chk("bad_op_error", err, 64'd1);
    chk("bad_op_ready", rdy, 64'd0);
    chk("bad_op_hold", hold, 64'd1);
    repeat (3) @(negedge CLK);
    chk("bad_op_no_write", log_addr.size(), 64'd0);
    pulse_start(1'b0);
    chk("retry_error_cleared", err, 64'd0);
    send(8'h0D, 1'b0, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    send(8'h04, 1'b1, 1'b0, 1'b0);
    idle_src();
    wait_end(1'b0);
    chk("retry_done", done, 64'd1);
    chk("retry_count", wcnt, 64'd1);
    chk("retry_writes", log_addr.size(), 64'd1);
    if (log_data.size() == 1) chk("retry_data", log_data[0], 64'h0D020304);

    // Bursty source
    two_word_load(1'b1);

    // Misaligned LAST
    log_addr.delete();
    log_data.delete();
    pulse_start(1'b0);
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h02, 1'b1, 1'b0, 1'b0);
    idle_src();
    chk("misalign_error", err, 64'd1);
    chk("misalign_count", wcnt, 64'd0);
    repeat (2) @(negedge CLK);
    chk("misalign_no_write", log_addr.size(), 64'd0);

    // Capacity on the 4-word instance: overflow, then exactly-full with LAST
    for (int run = 0; run < 2; run++) begin
      log_addr2.delete();
      log_data2.delete();
      pulse_start(1'b1);
      for (int k = 0; k < 4; k++) begin
        send(8'(k), 1'b0, 1'b1, 1'b0);
        send(8'h10 + 8'(k), 1'b0, 1'b1, 1'b0);
        send(8'h20 + 8'(k), 1'b0, 1'b1, 1'b0);
        send(8'h30 + 8'(k), (run == 1) && (k == 3), 1'b1, 1'b0);
      end
      idle_src();
      wait_end(1'b1);
      repeat (2) @(negedge CLK);
      chk(run == 0 ? "cap_error" : "cap_done", run == 0 ? err2 : done2, 64'd1);
      chk(run == 0 ? "cap_no_done" : "cap_no_error", run == 0 ? done2 : err2, 64'd0);
      chk("cap_count", wcnt2, 64'd4);
      chk("cap_writes", log_addr2.size(), 64'd4);
      if (log_addr2.size() == 4) begin
        for (int k = 0; k < 4; k++) begin
          chk("cap_addr", log_addr2[k], 64'(k));
          chk("cap_data", log_data2[k], {32'd0, 8'(k), 8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k)});
        end
      end
    end

    // Reset mid-word
    log_addr.delete();
    log_data.delete();
    pulse_start(1'b0);
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b0, 1'b0);
    send(8'h06, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", wcnt, 64'd1);
    RESET = 1'b0;
    #1;
    all_zero("rst_word");
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_ready", rdy, 64'd0);
    chk("post_rst_writes", log_addr.size(), 64'd1);

    // Reset during the write cycle
    idle_src();
    log_addr.delete();
    log_data.delete();
    pulse_start(1'b0);
    send(8'h07, 1'b0, 1'b0, 1'b0);
    send(8'h08, 1'b0, 1'b0, 1'b0);
    send(8'h09, 1'b0, 1'b0, 1'b0);
    send(8'h0A, 1'b0, 1'b0, 1'b0);
    idle_src();
    chk("write_cycle_we", we, 64'd1);
    RESET = 1'b0;
    #1;
    all_zero("rst_write");
    @(negedge CLK);
    chk("rst_write_no_write", log_addr.size(), 64'd0);
    RESET = 1'b1;
    BYTE_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_write_ready", rdy, 64'd0);
    idle_src();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
